// File: rtl/bus_arbiter_nm.sv
// N-master system-bus arbiter with fixed-priority or round-robin selection.
// Grants are held per transaction, with a hold timeout and a one-cycle handover gap.
module bus_arbiter_nm #(
   parameter int NUM_MASTERS = 4,
   parameter int SLAVE_SEL_W = 2,
   parameter int RR_MODE     = 0,
   parameter int MAX_HOLD    = 16,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic                               clk_i,
   input  logic                               rstn_i,
   input  logic [NUM_MASTERS-1:0]             m_request_i,
   input  logic [NUM_MASTERS*SLAVE_SEL_W-1:0] m_slave_sel_i,
   output logic [NUM_MASTERS-1:0]             m_grant_o,
   output logic [IDX_W-1:0]                   bus_grant_o,
   output logic                               grant_valid_o,
   output logic [SLAVE_SEL_W-1:0]             slave_sel_o,
   output logic                               arbiter_busy_o,
   output logic                               timeout_pulse_o
);

   localparam int                     HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0]      HOLD_SAT  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [NUM_MASTERS-1:0] ONE_HOT0  = NUM_MASTERS'(1);
   localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_MASTERS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   state_e                 state_q;
   logic [NUM_MASTERS-1:0] m_grant_q;
   logic [IDX_W-1:0]       bus_grant_q;
   logic                   grant_valid_q;
   logic [SLAVE_SEL_W-1:0] slave_sel_q;
   logic                   arbiter_busy_q;
   logic                   timeout_pulse_q;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [HOLD_W-1:0]      hold_q;
   logic [NUM_MASTERS-1:0] mask_q;

   logic [NUM_MASTERS-1:0] unmasked_d;
   logic [NUM_MASTERS-1:0] fix_cand_d;
   logic [IDX_W-1:0]       fix_idx_d;
   logic [IDX_W-1:0]       rr_idx_d;
   logic [IDX_W-1:0]       win_idx_d;
   logic [IDX_W-1:0]       rr_ptr_d;
   logic [SLAVE_SEL_W-1:0] win_sel_d;
   int                     rr_dist_d;
   int                     rr_best_d;
   logic                   any_req_d;
   logic                   owner_req_d;
   logic                   other_req_d;
   logic                   force_rel_d;
   logic [HOLD_W-1:0]      hold_inc_d;

   // Winner selection: masked fixed priority, or nearest requester at/after the RR pointer.
   always_comb begin
      unmasked_d = m_request_i & ~mask_q;
      if (|unmasked_d) begin
         fix_cand_d = unmasked_d;
      end else begin
         fix_cand_d = m_request_i;
      end

      fix_idx_d = {IDX_W{1'b0}};
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (fix_cand_d[i]) begin
            fix_idx_d = IDX_W'(i);
         end else begin
            fix_idx_d = fix_idx_d;
         end
      end

      rr_idx_d  = {IDX_W{1'b0}};
      rr_best_d = NUM_MASTERS;
      rr_dist_d = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         rr_dist_d = (i >= int'(rr_ptr_q)) ? (i - int'(rr_ptr_q))
                                           : (i + NUM_MASTERS - int'(rr_ptr_q));
         if (m_request_i[i] && (rr_dist_d < rr_best_d)) begin
            rr_best_d = rr_dist_d;
            rr_idx_d  = IDX_W'(i);
         end else begin
            rr_best_d = rr_best_d;
         end
      end

      win_idx_d = (RR_MODE != 0) ? rr_idx_d : fix_idx_d;

      win_sel_d = {SLAVE_SEL_W{1'b0}};
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (win_idx_d == IDX_W'(i)) begin
            win_sel_d = m_slave_sel_i[i*SLAVE_SEL_W +: SLAVE_SEL_W];
         end else begin
            win_sel_d = win_sel_d;
         end
      end

      rr_ptr_d = (win_idx_d == IDX_LAST) ? {IDX_W{1'b0}} : (win_idx_d + IDX_W'(1));
   end

   // Release conditions for the current owner.
   always_comb begin
      any_req_d   = |m_request_i;
      owner_req_d = |(m_request_i & m_grant_q);
      other_req_d = |(m_request_i & ~m_grant_q);
      force_rel_d = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && other_req_d;
      hold_inc_d  = (hold_q == HOLD_SAT) ? hold_q : (hold_q + HOLD_W'(1));
   end

   // Arbiter FSM; every output is a register updated here.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q         <= ST_IDLE;
         m_grant_q       <= {NUM_MASTERS{1'b0}};
         bus_grant_q     <= {IDX_W{1'b0}};
         grant_valid_q   <= 1'b0;
         slave_sel_q     <= {SLAVE_SEL_W{1'b0}};
         arbiter_busy_q  <= 1'b0;
         timeout_pulse_q <= 1'b0;
         rr_ptr_q        <= {IDX_W{1'b0}};
         hold_q          <= {HOLD_W{1'b0}};
         mask_q          <= {NUM_MASTERS{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE, ST_RELEASE: begin
               timeout_pulse_q <= 1'b0;
               hold_q          <= {HOLD_W{1'b0}};
               mask_q          <= {NUM_MASTERS{1'b0}};
               if (any_req_d) begin
                  state_q        <= ST_GRANT;
                  m_grant_q      <= ONE_HOT0 << win_idx_d;
                  bus_grant_q    <= win_idx_d;
                  grant_valid_q  <= 1'b1;
                  slave_sel_q    <= win_sel_d;
                  arbiter_busy_q <= 1'b1;
                  rr_ptr_q       <= rr_ptr_d;
               end else begin
                  state_q        <= ST_IDLE;
                  m_grant_q      <= {NUM_MASTERS{1'b0}};
                  bus_grant_q    <= {IDX_W{1'b0}};
                  grant_valid_q  <= 1'b0;
                  slave_sel_q    <= {SLAVE_SEL_W{1'b0}};
                  arbiter_busy_q <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (!owner_req_d || force_rel_d) begin
                  // A normal release wins over a coincident timeout: no pulse, no mask.
                  state_q         <= ST_RELEASE;
                  m_grant_q       <= {NUM_MASTERS{1'b0}};
                  bus_grant_q     <= {IDX_W{1'b0}};
                  grant_valid_q   <= 1'b0;
                  slave_sel_q     <= {SLAVE_SEL_W{1'b0}};
                  arbiter_busy_q  <= 1'b1;
                  hold_q          <= {HOLD_W{1'b0}};
                  timeout_pulse_q <= owner_req_d;
                  mask_q          <= owner_req_d ? (mask_q | m_grant_q) : mask_q;
               end else begin
                  hold_q          <= hold_inc_d;
                  timeout_pulse_q <= 1'b0;
               end
            end
            default: begin
               state_q         <= ST_IDLE;
               m_grant_q       <= {NUM_MASTERS{1'b0}};
               bus_grant_q     <= {IDX_W{1'b0}};
               grant_valid_q   <= 1'b0;
               slave_sel_q     <= {SLAVE_SEL_W{1'b0}};
               arbiter_busy_q  <= 1'b0;
               timeout_pulse_q <= 1'b0;
               hold_q          <= {HOLD_W{1'b0}};
               mask_q          <= {NUM_MASTERS{1'b0}};
            end
         endcase
      end
   end

   assign m_grant_o       = m_grant_q;
   assign bus_grant_o     = bus_grant_q;
   assign grant_valid_o   = grant_valid_q;
   assign slave_sel_o     = slave_sel_q;
   assign arbiter_busy_o  = arbiter_busy_q;
   assign timeout_pulse_o = timeout_pulse_q;

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter share stimulus and are
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_bus_arbiter_nm;

   localparam int N  = 4;
   localparam int MH = 8;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] bg;
      logic       v;
      logic [1:0] ss;
      logic       busy;
      logic       to;
   } obs_t;

   typedef struct {
      int   phase;
      obs_t fx;
      obs_t rr;
   } ent_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] req;
   logic [7:0] sel;

   logic [3:0] fx_g, rr_g;
   logic [1:0] fx_bg, rr_bg, fx_ss, rr_ss;
   logic       fx_v, rr_v, fx_busy, rr_busy, fx_to, rr_to;

   always #5 clk = ~clk;

   bus_arbiter_nm #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .RR_MODE(0), .MAX_HOLD(8)) dut_fx (
      .clk_i(clk), .rstn_i(rstn), .m_request_i(req), .m_slave_sel_i(sel),
      .m_grant_o(fx_g), .bus_grant_o(fx_bg), .grant_valid_o(fx_v), .slave_sel_o(fx_ss),
      .arbiter_busy_o(fx_busy), .timeout_pulse_o(fx_to));

   bus_arbiter_nm #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .RR_MODE(1), .MAX_HOLD(8)) dut_rr (
      .clk_i(clk), .rstn_i(rstn), .m_request_i(req), .m_slave_sel_i(sel),
      .m_grant_o(rr_g), .bus_grant_o(rr_bg), .grant_valid_o(rr_v), .slave_sel_o(rr_ss),
      .arbiter_busy_o(rr_busy), .timeout_pulse_o(rr_to));

   ent_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   phase = 0;

   // reference model state, index 0 = fixed priority, 1 = round robin
   int         own[2];
   int         held[2];
   int         ptr[2];
   int         masked[2];
   bit         gap[2];
   bit         pulse[2];
   logic [1:0] lsel[2];

   // observation counters filled by the monitor
   int   run4 = 0, to4 = 0, held5 = 0, to5 = 0, n6sel = 0, n6zero = 0;
   bit   seen_to4 = 1'b0;
   bit   last_rr_v = 1'b0;
   int   rr_order[$];
   int   exp3[5] = '{0, 1, 2, 3, 0};

   // stimulus working variables
   logic [3:0] rq_v;
   logic       r_v;
   int         ten[4];
   int         lim[4];
   int         prev3, ten3;

   function automatic int pick(input int m, input logic [3:0] rq);
      if (m == 1) begin
         for (int k = 0; k < N; k++) begin
            if (rq[(ptr[1] + k) % N]) return (ptr[1] + k) % N;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (rq[i] && i != masked[0]) return i;
         end
         for (int i = 0; i < N; i++) begin
            if (rq[i]) return i;
         end
      end
      return 0;
   endfunction

   task automatic model_step(input int m, input logic r, input logic [3:0] rq, input logic [7:0] sl);
      int w;
      bit others;
      pulse[m] = 1'b0;
      if (!r) begin
         own[m] = -1; gap[m] = 1'b0; held[m] = 0; ptr[m] = 0; masked[m] = -1; lsel[m] = 2'b00;
      end else if (own[m] >= 0) begin
         others = 1'b0;
         for (int j = 0; j < N; j++) begin
            if (j != own[m] && rq[j]) others = 1'b1;
         end
         if (!rq[own[m]]) begin
            own[m] = -1; gap[m] = 1'b1;
         end else if (held[m] == MH - 1 && others) begin
            masked[m] = own[m]; own[m] = -1; gap[m] = 1'b1; pulse[m] = 1'b1;
         end else if (held[m] < MH) begin
            held[m]++;
         end
      end else if (rq != 4'b0000) begin
         w = pick(m, rq);
         own[m] = w; lsel[m] = sl[w*2 +: 2]; ptr[m] = (w + 1) % N;
         masked[m] = -1; held[m] = 0; gap[m] = 1'b0;
      end else begin
         own[m] = -1; gap[m] = 1'b0; masked[m] = -1; held[m] = 0;
      end
   endtask

   function automatic obs_t mexp(input int m);
      obs_t o;
      o.g    = (own[m] >= 0) ? 4'(1 << own[m]) : 4'b0000;
      o.bg   = (own[m] >= 0) ? 2'(own[m]) : 2'b00;
      o.v    = (own[m] >= 0);
      o.ss   = (own[m] >= 0) ? lsel[m] : 2'b00;
      o.busy = (own[m] >= 0) || gap[m];
      o.to   = pulse[m];
      return o;
   endfunction

   task automatic cyc(input logic r, input logic [3:0] rq, input logic [7:0] sl);
      ent_t e;
      @(negedge clk);
      rstn = r; req = rq; sel = sl;
      model_step(0, r, rq, sl);
      model_step(1, r, rq, sl);
      e.phase = phase; e.fx = mexp(0); e.rr = mexp(1);
      sb.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
   endtask

   task automatic chk(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", nm, got, want);
      end
   endtask

   // monitor: pops one expected entry per clock and compares both instances
   initial begin : monitor
      ent_t e;
      obs_t afx, arr;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            afx = {fx_g, fx_bg, fx_v, fx_ss, fx_busy, fx_to};
            arr = {rr_g, rr_bg, rr_v, rr_ss, rr_busy, rr_to};
            total++;
            if (afx !== e.fx) begin
               bad++;
               $display("FAIL fixed t=%0t phase=%0d got g=%b bg=%0d v=%b ss=%b busy=%b to=%b want g=%b bg=%0d v=%b ss=%b busy=%b to=%b",
                        $time, e.phase, afx.g, afx.bg, afx.v, afx.ss, afx.busy, afx.to,
                        e.fx.g, e.fx.bg, e.fx.v, e.fx.ss, e.fx.busy, e.fx.to);
            end
            total++;
            if (arr !== e.rr) begin
               bad++;
               $display("FAIL rr t=%0t phase=%0d got g=%b bg=%0d v=%b ss=%b busy=%b to=%b want g=%b bg=%0d v=%b ss=%b busy=%b to=%b",
                        $time, e.phase, arr.g, arr.bg, arr.v, arr.ss, arr.busy, arr.to,
                        e.rr.g, e.rr.bg, e.rr.v, e.rr.ss, e.rr.busy, e.rr.to);
            end
            if (e.phase == 3 && arr.v && !last_rr_v) rr_order.push_back(int'(arr.bg));
            last_rr_v = arr.v;
            if (e.phase == 4) begin
               if (afx.g == 4'b0001 && !seen_to4) run4++;
               if (afx.to) begin
                  to4++;
                  seen_to4 = 1'b1;
               end
            end
            if (e.phase == 5) begin
               if (afx.g == 4'b0001) held5++;
               if (afx.to || arr.to) to5++;
            end
            if (e.phase == 6) begin
               if (afx.v && afx.ss == 2'b01) n6sel++;
               if (afx == 11'b0) n6zero++;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin : driver
      rstn = 1'b0; req = 4'b0000; sel = 8'h00;
      own[0] = -1; own[1] = -1;

      // 1: reset, single request from m2 with select 11
      phase = 1;
      cyc(1'b0, 4'b0000, 8'h00);
      cyc(1'b0, 4'b0000, 8'h00);
      repeat (3) cyc(1'b1, 4'b0100, 8'h30);
      repeat (3) cyc(1'b1, 4'b0000, 8'h30);

      // 2: contention 1110, then m1 drops
      phase = 2;
      repeat (4) cyc(1'b1, 4'b1110, 8'($urandom));
      repeat (4) cyc(1'b1, 4'b1100, 8'($urandom));
      repeat (2) cyc(1'b1, 4'b0000, 8'h00);

      // 3: all request, each owner (round-robin view) drops after 3 grant cycles
      phase = 0;
      cyc(1'b0, 4'b0000, 8'h00);
      phase = 3;
      prev3 = -1; ten3 = 0;
      for (int c = 0; c < 24; c++) begin
         rq_v = 4'b1111;
         if (own[1] >= 0) begin
            ten3  = (own[1] == prev3) ? ten3 + 1 : 1;
            prev3 = own[1];
            if (ten3 >= 3) rq_v[own[1]] = 1'b0;
         end else begin
            prev3 = -1; ten3 = 0;
         end
         cyc(1'b1, rq_v, 8'($urandom));
      end
      drain();
      chk("t3_order_len", (rr_order.size() >= 5) ? 1 : 0, 1);
      if (rr_order.size() >= 5) begin
         for (int k = 0; k < 5; k++) chk("t3_order", rr_order[k], exp3[k]);
      end

      // 4: timeout on m0 when m1 waits
      phase = 0;
      cyc(1'b0, 4'b0000, 8'h00);
      phase = 4;
      repeat (2)  cyc(1'b1, 4'b0001, 8'($urandom));
      repeat (12) cyc(1'b1, 4'b0011, 8'($urandom));
      repeat (5)  cyc(1'b1, 4'b0001, 8'($urandom));
      drain();
      chk("t4_hold_cycles", run4, 8);
      chk("t4_pulses", to4, 1);

      // 5: unopposed owner never times out
      phase = 0;
      cyc(1'b0, 4'b0000, 8'h00);
      phase = 5;
      repeat (40) cyc(1'b1, 4'b0001, 8'($urandom));
      drain();
      chk("t5_grant_cycles", held5, 40);
      chk("t5_pulses", to5, 0);

      // 6: select change during grant, reset mid-grant, re-arbitration
      phase = 0;
      cyc(1'b0, 4'b0000, 8'h00);
      phase = 6;
      repeat (3) cyc(1'b1, 4'b1000, 8'h40);
      repeat (3) cyc(1'b1, 4'b1000, 8'h80);
      cyc(1'b0, 4'b1000, 8'h80);
      repeat (3) cyc(1'b1, 4'b1000, 8'h80);
      repeat (2) cyc(1'b1, 4'b0000, 8'h00);
      drain();
      chk("t6_sel_held", n6sel, 6);
      chk("t6_zero_cycles", n6zero, 2);

      // 7: random traffic, tenure limits reach past the timeout
      phase = 7;
      rq_v = 4'b0000;
      for (int i = 0; i < N; i++) begin
         ten[i] = 0;
         lim[i] = 1;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!rq_v[i]) begin
               ten[i] = 0;
               if ($urandom_range(0, 2) == 0) begin
                  rq_v[i] = 1'b1;
                  lim[i]  = $urandom_range(1, 12);
               end
            end else if (own[0] == i) begin
               ten[i]++;
               if (ten[i] >= lim[i]) rq_v[i] = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
               rq_v[i] = 1'b0;
            end
         end
         r_v = ($urandom_range(0, 199) != 0);
         cyc(r_v, rq_v, 8'($urandom));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
